// File: rtl/mem_responder.sv
// mem_responder: memory-side slave for the CPU's multicycle memory interface.
// Serves word-aligned reads and byte-masked writes from a local word array.
// Every completed request gets one mem_resp pulse, LATENCY cycles after the
// request is first seen. A request dropped before completion is abandoned
// with no side effects.
module mem_responder #(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          LATENCY     = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [3:0]  mem_byte_enable,
  input  logic [31:0] mem_address,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        mem_resp,
  output logic        oob_err,
  output logic        proto_err
);

  localparam int          AW       = $clog2(DEPTH_WORDS);
  localparam logic [31:0] DEPTH32  = 32'(DEPTH_WORDS);
  localparam logic [3:0]  LAST_CNT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state_reg, state_next;
  logic [3:0]  cnt_reg, cnt_next;

  logic [31:0] byte_off;
  logic [31:0] word_off;
  logic        in_range;
  logic [AW-1:0] idx;

  logic        req;
  logic        both_req;
  logic        commit;
  logic        commit_read;
  logic        commit_write;
  logic        mem_we;

  logic [31:0] rdata_reg;
  logic        oob_reg;
  logic        proto_reg;

  logic [31:0] mem [DEPTH_WORDS];

  // Address decode: low two address bits are ignored. Underflow below
  // BASE_ADDR wraps the subtraction, so it is rejected explicitly.
  assign byte_off = mem_address - BASE_ADDR;
  assign word_off = byte_off >> 2;
  assign in_range = (mem_address >= BASE_ADDR) && (word_off < DEPTH32);
  assign idx      = word_off[AW-1:0];

  // Request qualification. When both strobes are high the access is
  // treated as a read, so a conflicting request never corrupts memory.
  assign req          = mem_read | mem_write;
  assign both_req     = mem_read & mem_write;
  assign commit_read  = commit & mem_read;
  assign commit_write = commit & mem_write & ~mem_read;

  // The array has no reset, so a write would otherwise still land on an
  // edge where rst is high. Gating with rst keeps an aborted write out.
  assign mem_we = commit_write & in_range & ~rst;

  // Next-state and counter logic; commit marks the edge that performs the access.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    commit     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (req) begin
          if (LATENCY == 1) begin
            state_next = RESP;
            cnt_next   = 4'd0;
            commit     = 1'b1;
          end else begin
            state_next = BUSY;
            cnt_next   = 4'd1;
          end
        end
      end
      BUSY: begin
        if (!req) begin
          // Initiator withdrew the request: abandon without side effects.
          state_next = IDLE;
          cnt_next   = 4'd0;
        end else if (cnt_reg == LAST_CNT) begin
          state_next = RESP;
          cnt_next   = 4'd0;
          commit     = 1'b1;
        end else begin
          cnt_next = cnt_reg + 4'd1;
        end
      end
      RESP: begin
        // Always one response cycle; a still-high request restarts from IDLE.
        state_next = IDLE;
        cnt_next   = 4'd0;
      end
      default: begin
        state_next = IDLE;
        cnt_next   = 4'd0;
      end
    endcase
  end

  // State and latency counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= 4'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Read data register: updated only by a completed read, held otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_reg <= 32'h0;
    end else if (commit_read) begin
      rdata_reg <= in_range ? mem[idx] : 32'h0;
    end
  end

  // Sticky error flags, cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      oob_reg   <= 1'b0;
      proto_reg <= 1'b0;
    end else begin
      if (commit && !in_range) begin
        oob_reg <= 1'b1;
      end
      if (both_req && (state_reg == IDLE || state_reg == BUSY)) begin
        proto_reg <= 1'b1;
      end
    end
  end

  // Byte-masked array write at the commit edge; unselected lanes keep their value.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (mem_byte_enable[i]) begin
          mem[idx][8*i +: 8] <= mem_wdata[8*i +: 8];
        end
      end
    end
  end

  assign mem_rdata = rdata_reg;
  assign mem_resp  = (state_reg == RESP);
  assign oob_err   = oob_reg;
  assign proto_err = proto_reg;

endmodule
